// File: rtl/forwarding_scoreboard_pkg.sv
// Shared types and default sizing for the EX/MEM forwarding scoreboard.
// The scoreboard records, selects and regfile-select constant live here.
package forwarding_scoreboard_pkg;

  localparam int unsigned NUM_REGS     = 8;
  localparam int unsigned REG_IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned FWD_DEPTH    = 3;
  localparam int unsigned FWD_NUM_SRC  = 3;
  localparam int unsigned FWD_LOAD_LAT = 2;
  localparam int unsigned FWD_SEL_W    = $clog2(FWD_DEPTH + 1);

  typedef logic [REG_IDX_W-1:0] lc3b_reg;
  typedef logic [FWD_SEL_W-1:0] lc3b_fwd_sel;

  localparam lc3b_fwd_sel FWD_SEL_REGFILE = '0;

  typedef struct packed {
    logic    valid;
    lc3b_reg dest;
    logic    is_load;
  } fwd_rec_t;

endpackage

// File: rtl/forwarding_scoreboard_fwd_match.sv
// Per-operand priority encoder: finds the youngest in-flight writer of one
// source register and flags a load whose data is not yet forwardable.
module fwd_match
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH    = FWD_DEPTH,
  parameter int unsigned LOAD_LAT = FWD_LOAD_LAT,
  parameter int unsigned SEL_W    = FWD_SEL_W
) (
  input  fwd_rec_t [DEPTH-1:0] slots_i,
  input  lc3b_reg              src_i,
  input  logic                 used_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 hit_o,
  output logic                 hazard_o
);

  // Scan oldest to youngest so the smallest matching index is the last write.
  always_comb begin
    sel_o    = SEL_W'(FWD_SEL_REGFILE);
    hit_o    = 1'b0;
    hazard_o = 1'b0;
    if (used_i) begin
      for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
        if (slots_i[j].valid && (slots_i[j].dest == src_i)) begin
          hit_o    = 1'b1;
          sel_o    = SEL_W'(j + 1);
          hazard_o = slots_i[j].is_load && ((32'(j) + 32'd1) < LOAD_LAT);
        end
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks in-flight writers, registers EX forward selects
// and raises the load-use stall. Optional FWD_STATS_EN adds a stall counter.
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter  int unsigned DEPTH    = FWD_DEPTH,
  parameter  int unsigned NUM_SRC  = FWD_NUM_SRC,
  parameter  int unsigned LOAD_LAT = FWD_LOAD_LAT,
  localparam int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         advance,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic                         id_load_regfile,
  input  logic [REG_IDX_W-1:0]         id_dest,
  input  logic                         id_is_load,
  input  logic [NUM_SRC*REG_IDX_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]           id_src_used,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel_ex,
  output logic                         stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]                  stall_count
`endif
);

  fwd_rec_t [DEPTH-1:0]       slots_q, slots_d;
  fwd_rec_t                   save_q, save_d;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel_ex_q, fwd_sel_ex_d;
  logic [NUM_SRC*SEL_W-1:0]   cand_sel;
  logic [NUM_SRC-1:0]         hit;
  logic [NUM_SRC-1:0]         hazard;
  logic                       unused_save;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
    fwd_match #(
      .DEPTH   (DEPTH),
      .LOAD_LAT(LOAD_LAT),
      .SEL_W   (SEL_W)
    ) u_match (
      .slots_i (slots_q),
      .src_i   (id_src[k*REG_IDX_W +: REG_IDX_W]),
      .used_i  (id_src_used[k] && id_valid),
      .sel_o   (cand_sel[k*SEL_W +: SEL_W]),
      .hit_o   (hit[k]),
      .hazard_o(hazard[k])
    );
  end

  assign stall       = |(hit & hazard);
  assign fwd_sel_ex  = fwd_sel_ex_q;
  // The save slot's record is only a select target for the datapath.
  assign unused_save = ^save_q;

  // Shift the scoreboard on advance; stalls and flushes insert bubbles.
  always_comb begin
    slots_d      = slots_q;
    save_d       = save_q;
    fwd_sel_ex_d = fwd_sel_ex_q;
    if (advance) begin
      save_d = slots_q[DEPTH-1];
      for (int j = 1; j < int'(DEPTH); j++) begin
        slots_d[j] = slots_q[j-1];
        if (flush && (j == 1)) begin
          slots_d[j].valid = 1'b0;
        end
      end
      slots_d[0].valid   = id_valid && id_load_regfile && !stall && !flush;
      slots_d[0].dest    = id_dest;
      slots_d[0].is_load = id_is_load;
      fwd_sel_ex_d       = (stall || flush) ? '0 : cand_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_q      <= '0;
      save_q       <= '0;
      fwd_sel_ex_q <= '0;
    end else begin
      slots_q      <= slots_d;
      save_q       <= save_d;
      fwd_sel_ex_q <= fwd_sel_ex_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] stall_count_q;

  // Saturating count of cycles in which a stall actually holds the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (stall && advance && !flush && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed scoreboard bench for forwarding_scoreboard: the driver queues the
// expected stall/select per cycle, the monitor pops and compares on each sample.
module tb_forwarding_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       advance;
  logic       flush;
  logic       id_valid;
  logic       id_load_regfile;
  logic [2:0] id_dest;
  logic       id_is_load;
  logic [8:0] id_src;
  logic [2:0] id_src_used;
  logic [5:0] fwd_sel_ex;
  logic       stall;
`ifdef FWD_STATS_EN
  logic [15:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      nm;
    logic       stall;
    logic [5:0] sel;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;

  forwarding_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .advance        (advance),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_load_regfile(id_load_regfile),
    .id_dest        (id_dest),
    .id_is_load     (id_is_load),
    .id_src         (id_src),
    .id_src_used    (id_src_used),
    .fwd_sel_ex     (fwd_sel_ex),
    .stall          (stall)
`ifdef FWD_STATS_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) -> sample_ev;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (stall !== e.stall) begin
          bad++;
          $display("FAIL %s stall got=%0b want=%0b", e.nm, stall, e.stall);
        end
        total++;
        if (fwd_sel_ex !== e.sel) begin
          bad++;
          $display("FAIL %s fwd_sel_ex got=%0d want=%0d", e.nm, fwd_sel_ex, e.sel);
        end
      end
    end
  end

  // One ID-stage cycle: drive inputs after the edge, queue what the monitor must see.
  task automatic vec(input string nm, input logic adv, input logic fl,
                     input logic v, input logic lr, input logic [2:0] dest,
                     input logic ld, input logic [2:0] s0, input logic [2:0] s1,
                     input logic [2:0] s2, input logic [2:0] used,
                     input logic exp_stall, input logic [5:0] exp_sel);
    exp_t e;
    @(posedge clk);
    #1;
    advance         = adv;
    flush           = fl;
    id_valid        = v;
    id_load_regfile = lr;
    id_dest         = dest;
    id_is_load      = ld;
    id_src          = {s2, s1, s0};
    id_src_used     = used;
    e.nm    = nm;
    e.stall = exp_stall;
    e.sel   = exp_sel;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    advance = 1'b0; flush = 1'b0; id_valid = 1'b0; id_load_regfile = 1'b0;
    id_dest = '0; id_is_load = 1'b0; id_src = '0; id_src_used = '0;
    e.nm = "reset"; e.stall = 1'b0; e.sel = 6'd0;
    exp_q.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    //   name        adv fl v  lr dest ld s0 s1 s2 used  stall sel
    vec("a1_add_r1", 1, 0, 1, 1, 3'd1, 0, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("a2_use_r1", 1, 0, 1, 1, 3'd2, 0, 1, 1, 0, 3'b011, 0, 6'd0);
    vec("a3_sel_11", 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 6'd5);

    vec("b1_ldr_r3", 1, 0, 1, 1, 3'd3, 1, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("b2_lduse",  1, 0, 1, 1, 3'd4, 0, 3, 0, 0, 3'b001, 1, 6'd0);
    vec("b3_resume", 1, 0, 1, 1, 3'd4, 0, 3, 0, 0, 3'b001, 0, 6'd0);
    vec("b4_sel_2",  1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 6'd2);

    vec("c1_add_r5", 1, 0, 1, 1, 3'd5, 0, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("c2_add_r5", 1, 0, 1, 1, 3'd5, 0, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("c3_use_r5", 1, 0, 1, 1, 3'd6, 0, 5, 0, 0, 3'b001, 0, 6'd0);
    vec("c4_young",  1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 6'd1);

    vec("d1_add_r7", 1, 0, 1, 1, 3'd7, 0, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("d2_nop",    1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("d3_nop",    1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("d4_wb_r7",  1, 0, 1, 1, 3'd0, 0, 0, 7, 0, 3'b010, 0, 6'd0);
    vec("d5_save",   1, 0, 1, 0, 3'd0, 0, 7, 0, 0, 3'b001, 0, 6'd12);
    vec("d6_r0_mem", 1, 0, 1, 0, 3'd0, 0, 0, 0, 0, 3'b010, 0, 6'd0);
    vec("d7_sel_2",  1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 6'd8);

    vec("e1_ldr_r1", 1, 0, 1, 1, 3'd1, 1, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("e2_flush",  1, 1, 1, 1, 3'd2, 0, 1, 0, 0, 3'b001, 1, 6'd0);
    vec("e3_clean",  1, 0, 1, 1, 3'd2, 0, 1, 0, 0, 3'b001, 0, 6'd0);
    vec("e4_nofwd",  1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 6'd0);

    vec("f1_add_r6", 1, 0, 1, 1, 3'd6, 0, 0, 0, 0, 3'b000, 0, 6'd0);
    vec("f2_ldr_r3", 1, 0, 1, 1, 3'd3, 1, 6, 0, 0, 3'b001, 0, 6'd0);
    vec("f3_hold",   0, 0, 1, 1, 3'd4, 0, 3, 0, 0, 3'b001, 1, 6'd1);
    vec("f4_hold",   0, 0, 1, 1, 3'd4, 0, 3, 0, 0, 3'b001, 1, 6'd1);
    vec("f5_hold",   0, 0, 1, 1, 3'd4, 0, 3, 0, 0, 3'b001, 1, 6'd1);
    vec("f6_unused", 0, 0, 1, 1, 3'd4, 0, 3, 0, 0, 3'b000, 0, 6'd1);
    vec("f7_hold",   0, 0, 1, 1, 3'd4, 0, 3, 0, 0, 3'b001, 1, 6'd1);

    // Asynchronous reset between edges while the hazard is pending.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    e.nm = "rst_async"; e.stall = 1'b0; e.sel = 6'd0;
    exp_q.push_back(e);
    -> sample_ev;
`ifdef FWD_STATS_EN
    total++;
    if (stall_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_count stall_count got=%0d want=0", stall_count);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    vec("g1_empty",  1, 0, 1, 1, 3'd4, 0, 3, 0, 0, 3'b001, 0, 6'd0);
    vec("g2_use_r4", 1, 0, 1, 1, 3'd1, 0, 4, 0, 4, 3'b101, 0, 6'd0);
    vec("g3_op2",    1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 6'd17);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
